bit_extender_core: RTL and testbench
====================================

// Module: bit_extender_core
// PURPOSE
//   Immediate-field extender for the MIPS datapath: widens the 16-bit
//   instruction immediate X to a 32-bit operand Z for the ALU/address path.
//   Supports sign extension (default), zero extension and, optionally,
//   upper-immediate placement.
//   Output is registered, so Z lags X by one clock in the decode->execute stage.
// PARAMETERS
//   IN_W   16  width of immediate input X
//   OUT_W  32  width of extended output Z; must be > IN_W (elaboration error otherwise)
// PORTS
//   clk        input   1      single clock, rising edge
//   rst_n      input   1      asynchronous, active-low reset
//   X          input   IN_W   immediate to extend
//   mode       input   2      00 sign-ext, 01 zero-ext, 10 upper-imm, 11 reserved
//   in_valid   input   1      X/mode valid this cycle
//   Z          output  OUT_W  extended result (registered)
//   out_valid  output  1      Z holds a fresh result (registered)
// BEHAVIOUR
//   - Interface: one clock (clk); reset is asynchronous, active-low (rst_n).
//   - Reset asserted (any time, incl. mid-operation): Z=0, out_valid=0 at once;
//     first capture is on the first rising clk after rst_n deasserts.
//   - Latency 1 cycle: on rising clk with in_valid=1, Z <= f(X,mode),
//     out_valid <= 1. With in_valid=0: Z holds its last value, out_valid <= 0.
//   - No backpressure; a new input is accepted every cycle.
//   - mode 00: Z = {{(OUT_W-IN_W){X[IN_W-1]}}, X}  (sign extension).
//   - mode 01: Z = {{(OUT_W-IN_W){1'b0}}, X}       (zero extension).
//   - mode 10: see CONFIGURATION.
//   - mode 11 (reserved): treated exactly as mode 00.
//   - Boundaries: X=0x7FFF -> 0x00007FFF; X=0x8000 -> 0xFFFF8000;
//     X=0xFFFF -> 0xFFFFFFFF (sign) / 0x0000FFFF (zero).
//   - Purely data-path: no FSM, no X/Z propagation from unused bits; mode
//     decoding is a full case with sign extension as the default.
// CONFIGURATION
//   Macro BIT_EXTENDER_UPPER_IMM_EN:
//   - defined: mode 10 gives Z = X << (OUT_W-IN_W), low bits zero
//     (LUI placement; 0x1234 -> 0x12340000).
//   - undefined: mode 10 is treated as mode 00 (sign extension); no extra logic.
// STRUCTURE
//   - bit_extender_pkg: localparams IN_W_DEF=16, OUT_W_DEF=32; mode encoding
//     constants EXT_SIGN=2'b00, EXT_ZERO=2'b01, EXT_UPPER=2'b10, EXT_RSVD=2'b11.
//   - One combinational sub-module ext_mux (X, mode -> next_Z) holding the
//     extension logic; top level holds the output/valid registers and the
//     width check.
// TESTING
//   1) Reset: rst_n=0 with X=0x000F, in_valid=1 -> Z=0x00000000, out_valid=0.
//   2) Sign-ext positive: X=0x000F, mode=00, in_valid=1 -> next cycle
//      Z=0x0000000F, out_valid=1.
//   3) Sign-ext negative: X=0x800F, mode=00 -> Z=0xFFFF800F; mode=11 same.
//   4) Zero-ext: X=0x800F, mode=01 -> Z=0x0000800F.
//   5) Upper-imm: X=0x1234, mode=10 -> Z=0x12340000 with the macro,
//      Z=0x00001234 without it.
//   6) Hold/async reset: in_valid=0 after case 3 -> Z stays 0xFFFF800F,
//      out_valid=0; rst_n pulsed low between clock edges -> Z=0 immediately.

Source files
------------

// File: rtl/bit_extender_pkg.sv
// bit_extender_pkg: default widths and mode encodings for the immediate extender.
package bit_extender_pkg;
    localparam int IN_W_DEF  = 16;
    localparam int OUT_W_DEF = 32;
    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;
    localparam logic [1:0] EXT_RSVD  = 2'b11;
endpackage

// File: rtl/bit_extender_core_ext_mux.sv
// ext_mux: combinational immediate widening; upper-imm placement only with
// BIT_EXTENDER_UPPER_IMM_EN, otherwise mode 10 falls back to sign extension.
module ext_mux
    import bit_extender_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [IN_W-1:0]  i_x,
    input  logic [1:0]       i_mode,
    output logic [OUT_W-1:0] o_next_z
);
    logic [OUT_W-1:0] w_sign;
    logic [OUT_W-1:0] w_zero;
    assign w_sign = {{(OUT_W-IN_W){i_x[IN_W-1]}}, i_x};
    assign w_zero = {{(OUT_W-IN_W){1'b0}}, i_x};
`ifdef BIT_EXTENDER_UPPER_IMM_EN
    logic [OUT_W-1:0] w_upper;
    assign w_upper = OUT_W'(i_x) << (OUT_W-IN_W);
`endif
    always_comb begin
        o_next_z = w_sign;
        case (i_mode)
            EXT_SIGN:  o_next_z = w_sign;
            EXT_ZERO:  o_next_z = w_zero;
`ifdef BIT_EXTENDER_UPPER_IMM_EN
            EXT_UPPER: o_next_z = w_upper;
`else
            EXT_UPPER: o_next_z = w_sign;
`endif
            EXT_RSVD:  o_next_z = w_sign;
            default:   o_next_z = w_sign;
        endcase
    end
endmodule

// File: rtl/bit_extender_core.sv
// bit_extender_core: registered immediate extender (sign/zero, optional upper-imm
// via BIT_EXTENDER_UPPER_IMM_EN); Z lags X by one clock.
module bit_extender_core
    import bit_extender_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  X,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic [OUT_W-1:0] Z,
    output logic             out_valid
);
    logic [OUT_W-1:0] w_next_z;
    logic [OUT_W-1:0] r_z;
    logic             r_valid;
    generate
        if (OUT_W <= IN_W) begin : g_bad_width
            $error("bit_extender_core: OUT_W must exceed IN_W");
        end
    endgenerate
    ext_mux #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ext_mux (
        .i_x      (X),
        .i_mode   (mode),
        .o_next_z (w_next_z)
    );
    // Z keeps its last value on idle cycles; only the valid flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) r_z <= w_next_z;
        end
    end
    assign Z         = r_z;
    assign out_valid = r_valid;
endmodule

// File: tb/tb_bit_extender_core.sv
// tb_bit_extender_core: scoreboard bench with an arithmetic reference model.
module tb_bit_extender_core;
`ifdef BIT_EXTENDER_UPPER_IMM_EN
    localparam bit UPPER = 1'b1;
`else
    localparam bit UPPER = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] X;
    logic [1:0]  mode;
    logic        in_valid;
    logic [31:0] Z;
    logic        out_valid;
    logic [32:0] exp_q[$];
    logic [31:0] exp_z;
    int errors = 0;
    int checks = 0;

    bit_extender_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .X         (X),
        .mode      (mode),
        .in_valid  (in_valid),
        .Z         (Z),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ext(input int x, input int m);
        longint r;
        if (m == 1) r = x;
        else if (m == 2 && UPPER) r = (longint'(x) * 65536) % 64'd4294967296;
        else if (x >= 32768) r = longint'(x) + 64'd4294967296 - 64'd65536;
        else r = x;
        return r[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic drive(input logic [15:0] x, input logic [1:0] m, input logic v);
        @(posedge clk);
        #2;
        X = x;
        mode = m;
        in_valid = v;
        if (v) exp_z = ref_ext(int'(x), int'(m));
        exp_q.push_back({v, exp_z});
    endtask

    initial begin : monitor
        logic [32:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n !== 1'b1) continue;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_valid", {31'b0, out_valid}, {31'b0, e[32]});
                check("Z", Z, e[31:0]);
            end else if (out_valid) begin
                check("unexpected out_valid", {31'b0, out_valid}, 32'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        X = 16'h000F;
        mode = 2'b00;
        in_valid = 1'b1;
        exp_z = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset Z", Z, 32'h0);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        drive(16'h000F, 2'b00, 1'b1);
        drive(16'h800F, 2'b00, 1'b1);
        drive(16'h800F, 2'b11, 1'b1);
        drive(16'h0000, 2'b00, 1'b0);
        drive(16'h1234, 2'b00, 1'b0);
        drive(16'h800F, 2'b01, 1'b1);
        drive(16'h1234, 2'b10, 1'b1);
        drive(16'h7FFF, 2'b00, 1'b1);
        drive(16'h8000, 2'b00, 1'b1);
        drive(16'hFFFF, 2'b00, 1'b1);
        drive(16'hFFFF, 2'b01, 1'b1);
        drive(16'hFFFF, 2'b10, 1'b1);
        for (int i = 0; i < 60; i++)
            drive(16'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
        drive(16'h800F, 2'b00, 1'b1);
        drive(16'h0000, 2'b00, 1'b0);
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        check("async reset Z", Z, 32'h0);
        check("async reset out_valid", {31'b0, out_valid}, 32'd0);
        X = 16'h000F;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("held reset Z", Z, 32'h0);
        check("held reset out_valid", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_z = '0;
        drive(16'h8001, 2'b00, 1'b1);
        drive(16'h8001, 2'b01, 1'b1);
        drive(16'h0000, 2'b01, 1'b0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
